// File: rtl/phase_rot_scheduler.sv
// Round-robin scheduler sharing one 0..3-step right rotator among NREQ requesters; a rotation
// of any length is applied as a sequence of <=3-bit steps, one per clock.
module phase_rot_scheduler #(
  parameter int unsigned BITSTREAM = 64,
  parameter int unsigned NREQ      = 4,
  localparam int unsigned SHW      = $clog2(BITSTREAM),
  localparam int unsigned IDW      = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*BITSTREAM-1:0] req_bits,
  input  logic [NREQ*SHW-1:0]       req_shift,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [BITSTREAM-1:0]      rsp_bits,
  output logic [IDW-1:0]            rsp_id,
  output logic                      busy
);

  localparam int unsigned SumW = IDW + 1;

  typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

  state_e               state_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       id_q;
  logic [BITSTREAM-1:0] data_q;
  logic [SHW-1:0]       rem_q, rem_d;
  logic                 rsp_valid_q;
  logic                 busy_q;

  logic                 grant_vld;
  logic [IDW-1:0]       grant_idx;
  logic [BITSTREAM-1:0] sel_bits;
  logic [SHW-1:0]       sel_shift;
  logic [1:0]           rot_k;
  logic [BITSTREAM-1:0] rot_out;
  logic [IDW-1:0]       next_ptr;

  // Round-robin scan starting at rr_ptr_q, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    logic [SumW-1:0] sum;
    logic [IDW-1:0]  idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      sum = {1'b0, rr_ptr_q} + SumW'(off);
      if (sum >= SumW'(NREQ)) begin
        sum = sum - SumW'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_vld && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign sel_bits  = req_bits[grant_idx*BITSTREAM +: BITSTREAM];
  assign sel_shift = req_shift[grant_idx*SHW +: SHW];

  // Shared PHASE_2b rotator: right-rotate data_q by k in 0..3.
  assign rot_k = (rem_q >= SHW'(3)) ? 2'd3 : rem_q[1:0];
  assign rem_d = rem_q - SHW'(rot_k);

  always_comb begin
    unique case (rot_k)
      2'd0:    rot_out = data_q;
      2'd1:    rot_out = {data_q[0],   data_q[BITSTREAM-1:1]};
      2'd2:    rot_out = {data_q[1:0], data_q[BITSTREAM-1:2]};
      default: rot_out = {data_q[2:0], data_q[BITSTREAM-1:3]};
    endcase
  end

  assign next_ptr = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_vld) begin
            data_q <= sel_bits;
            rem_q  <= sel_shift;
            id_q   <= grant_idx;
            busy_q <= 1'b1;
            if (sel_shift == '0) begin
              state_q     <= StDone;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= StRotate;
            end
          end
        end
        StRotate: begin
          data_q <= rot_out;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q     <= StDone;
            rsp_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= next_ptr;
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_bits  = data_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  // A stalled response must not move until the consumer takes it.
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_bits) && $stable(rsp_id));

endmodule

// File: tb/tb_phase_rot_scheduler.sv
// Randomized bench for phase_rot_scheduler against a round-robin / rotate-right reference model.
module tb_phase_rot_scheduler;

  localparam int B   = 64;
  localparam int N   = 4;
  localparam int SHW = 6;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*B-1:0]   req_bits;
  logic [N*SHW-1:0] req_shift;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [B-1:0]     rsp_bits;
  logic [IDW-1:0]   rsp_id;
  logic             busy;

  logic [B-1:0]     m_bits  [N];
  logic [SHW-1:0]   m_shift [N];

  int n_checks = 0;
  int n_errors = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_bits  = '0;
    req_shift = '0;
    for (int i = 0; i < N; i++) begin
      req_bits[i*B +: B]       = m_bits[i];
      req_shift[i*SHW +: SHW]  = m_shift[i];
    end
  end

  phase_rot_scheduler #(
    .BITSTREAM(B),
    .NREQ     (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_bits (req_bits),
    .req_shift(req_shift),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_bits (rsp_bits),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  function automatic logic [B-1:0] rotr(input logic [B-1:0] x, input int s);
    if (s == 0) return x;
    return (x >> s) | (x << (B - s));
  endfunction

  function automatic int exp_grant(input logic [N-1:0] mask);
    for (int o = 0; o < N; o++) begin
      if (mask[(model_ptr + o) % N]) return (model_ptr + o) % N;
    end
    return 0;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: grant, rotate, optional consumer stall, handshake.
  task automatic run_req(input logic [N-1:0] mask, input int stall, output logic [B-1:0] res);
    int           g;
    int           lat;
    logic         bad;
    logic [N-1:0] exp_rdy;
    logic [B-1:0] hold_bits;
    logic [IDW-1:0] hold_id;
    g         = exp_grant(mask);
    exp_rdy   = '0;
    exp_rdy[g] = 1'b1;
    rsp_ready = 1'b0;
    req_valid = mask;
    #1;
    check_eq("grant", 64'(req_ready), 64'(exp_rdy));
    tick();
    req_valid = mask & ~exp_rdy;
    #1;
    lat = 0;
    bad = 1'b0;
    while (!rsp_valid && lat < 100) begin
      if (req_ready != '0 || !busy) bad = 1'b1;
      tick();
      lat++;
    end
    check_eq("latency", 64'(lat), 64'((int'(m_shift[g]) + 2) / 3));
    check_eq("bits", rsp_bits, rotr(m_bits[g], int'(m_shift[g])));
    check_eq("id", 64'(rsp_id), 64'(g));
    check_eq("ready_while_busy", 64'(bad), 64'(0));
    res       = rsp_bits;
    hold_bits = rsp_bits;
    hold_id   = rsp_id;
    if (stall > 0) begin
      bad = 1'b0;
      repeat (stall) begin
        tick();
        if (!rsp_valid || rsp_bits !== hold_bits || rsp_id !== hold_id || req_ready != '0) begin
          bad = 1'b1;
        end
      end
      check_eq("stall_hold", 64'(bad), 64'(0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rsp_drop", 64'({busy, rsp_valid}), 64'(0));
    model_ptr = (g + 1) % N;
    req_valid = mask;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [B-1:0] res;
    logic         bad;
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      m_bits[i]  = '0;
      m_shift[i] = '0;
    end
    repeat (3) tick();
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_bits", rsp_bits, 64'(0));
    check_eq("rst_rsp_id", 64'(rsp_id), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    rst       = 1'b0;
    req_valid = '0;
    model_ptr = 0;
    tick();

    m_bits[0] = 64'h1; m_shift[0] = 6'd5;
    run_req(4'b0001, 0, res);
    check_eq("t1_bits", res, 64'h0800_0000_0000_0000);

    m_bits[2] = 64'hDEAD_BEEF_0123_4567; m_shift[2] = 6'd0;
    run_req(4'b0100, 0, res);
    check_eq("t2_bits", res, 64'hDEAD_BEEF_0123_4567);

    m_bits[1] = 64'h8000_0000_0000_0001; m_shift[1] = 6'd63;
    run_req(4'b0010, 0, res);
    check_eq("t3_bits", res, 64'h3);

    // Fresh round-robin pointer, then all four continuously valid.
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < N; i++) begin
        m_bits[i]  = {$urandom, $urandom};
        m_shift[i] = SHW'($urandom_range(0, B - 1));
      end
      run_req(4'b1111, 0, res);
    end

    run_req(4'b1111, 10, res);
    req_valid = '0;
    tick();

    // Reset in the middle of a long rotation.
    m_bits[1]  = {$urandom, $urandom};
    m_shift[1] = 6'd63;
    req_valid  = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    repeat (3) tick();
    check_eq("t6_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_busy_after", 64'(busy), 64'(0));
    check_eq("t6_rsp_valid", 64'(rsp_valid), 64'(0));
    model_ptr = 0;
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (rsp_valid || busy) bad = 1'b1;
    end
    check_eq("t6_no_response", 64'(bad), 64'(0));
    run_req(4'b1111, 0, res);

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < N; i++) begin
        m_bits[i]  = {$urandom, $urandom};
        m_shift[i] = SHW'($urandom_range(0, B - 1));
      end
      run_req(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2), res);
    end
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
